seg7_scan_capture: RTL and testbench



---
 rtl/seg7_scan_capture_if.sv | 22 ++
 rtl/seg7_scan_capture.sv | 135 +++++++++++++
 tb/tb_seg7_scan_capture.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_capture_if.sv
// Display-bus snoop interface: active-low segment/anode lines in, decoded digit state out.
// master drives the display bus and observes results; slave is the capture block.
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    err;

  modport master (
    output seg_n, an_n,
    input  digits, digit_valid, frame_valid, err
  );

  modport slave (
    input  seg_n, an_n,
    output digits, digit_valid, frame_valid, err
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed active-low seven-segment bus: synchronize, debounce each
// digit dwell, decode the glyph back to hex and publish per-digit value registers.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_capture_if.slave bus
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic [NUM_DIGITS-1:0]   an_act;
  logic [NUM_DIGITS-1:0]   seen_nxt;
  logic [6:0]              glyph;
  logic [4:0]              dec;
  logic                    same, onehot, accept, blank;
  int                      n_act;

  // Returns {legal, value} for an active-high gfedcba glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    an_act = ~sync2_q[W-1:7];
    glyph  = ~sync2_q[6:0];
    same   = (sync2_q == prev_q);

    n_act = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) n_act = n_act + 1;
    end
    // Blanking (no anode) and ghosting (several anodes) are ignored silently.
    onehot = (n_act == 1);

    if (!same)                cnt_d = CNT_ONE;
    else if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    else                      cnt_d = cnt_q;

    accept = same && (cnt_q == CNT_ACC) && onehot;
    dec    = decode_glyph(glyph);
    blank  = (glyph == 7'h00);

    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;

    if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_act[i]) begin
          if (dec[4]) begin
            digits_d[4*i +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
          end else if (blank) begin
            digits_d[4*i +: 4] = 4'h0;
            valid_d[i]         = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d      = 1'b1;
          end
        end
      end
      seen_nxt = seen_q | an_act;
      if (&seen_nxt) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {bus.an_n, bus.seg_n};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: directed dwells push expected output
// events; a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_seg7_scan_capture;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  seg7_scan_capture_if #(.NUM_DIGITS(N)) bus_if ();

  seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [15:0] d;
    logic [3:0]  v;
    logic        f;
    logic        e;
  } exp_t;
  exp_t q[$];

  logic [15:0] prev_d = '0;
  logic [3:0]  prev_v = '0;

  // Monitor: any output change or pulse is an event that must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_d = bus_if.digits;
      prev_v = bus_if.digit_valid;
    end else if (bus_if.digits != prev_d || bus_if.digit_valid != prev_v ||
                 bus_if.frame_valid || bus_if.err) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event cyc=%0d digits=%h valid=%b frame=%b err=%b",
                 cyc, bus_if.digits, bus_if.digit_valid, bus_if.frame_valid, bus_if.err);
      end else begin
        exp_t x;
        x = q.pop_front();
        tests++;
        if (cyc != x.at) begin
          fails++; $display("FAIL event_cycle got=%0d want=%0d", cyc, x.at);
        end
        tests++;
        if (bus_if.digits != x.d) begin
          fails++; $display("FAIL digits got=%h want=%h (cyc %0d)", bus_if.digits, x.d, cyc);
        end
        tests++;
        if (bus_if.digit_valid != x.v) begin
          fails++; $display("FAIL digit_valid got=%b want=%b (cyc %0d)", bus_if.digit_valid, x.v, cyc);
        end
        tests++;
        if (bus_if.frame_valid != x.f) begin
          fails++; $display("FAIL frame_valid got=%b want=%b (cyc %0d)", bus_if.frame_valid, x.f, cyc);
        end
        tests++;
        if (bus_if.err != x.e) begin
          fails++; $display("FAIL err got=%b want=%b (cyc %0d)", bus_if.err, x.e, cyc);
        end
      end
      prev_d = bus_if.digits;
      prev_v = bus_if.digit_valid;
    end
  end

  // Drive one dwell after an edge; if an acceptance is expected it lands 6 edges later.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n,
                       input bit expect_ev, input logic [15:0] d, input logic [3:0] v,
                       input bit f, input bit e);
    exp_t x;
    @(posedge clk); #1;
    bus_if.an_n  = an;
    bus_if.seg_n = seg;
    if (expect_ev) begin
      x.at = cyc + 6; x.d = d; x.v = v; x.f = f; x.e = e;
      q.push_back(x);
    end
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if (bus_if.digits != 16'h0 || bus_if.digit_valid != 4'h0 ||
        bus_if.frame_valid || bus_if.err) begin
      fails++;
      $display("FAIL %s got digits=%h valid=%b frame=%b err=%b want all zero", tag,
               bus_if.digits, bus_if.digit_valid, bus_if.frame_valid, bus_if.err);
    end
  endtask

  initial begin
    exp_t x;
    bus_if.an_n  = 4'($urandom);
    bus_if.seg_n = 7'($urandom);
    repeat (3) @(posedge clk);
    #2 check_zero("reset_state");
    bus_if.an_n = 4'hF; bus_if.seg_n = 7'h7F;
    @(negedge clk); rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #2 check_zero("idle_after_reset");

    // single digit "3", then a too-short dwell on digit 1
    dwell(4'b1110, 7'h30, 10, 1, 16'h0003, 4'b0001, 0, 0);
    dwell(4'b1111, 7'h7F, 10, 0, '0, '0, 0, 0);
    dwell(4'b1101, 7'h12, 3,  0, '0, '0, 0, 0);
    dwell(4'b1111, 7'h7F, 10, 0, '0, '0, 0, 0);

    // full frame "0","1","2","A"
    dwell(4'b1110, 7'h40, 8, 1, 16'h0000, 4'b0001, 0, 0);
    dwell(4'b1101, 7'h79, 8, 1, 16'h0010, 4'b0011, 0, 0);
    dwell(4'b1011, 7'h24, 8, 1, 16'h0210, 4'b0111, 0, 0);
    dwell(4'b0111, 7'h08, 8, 1, 16'hA210, 4'b1111, 1, 0);
    // next scan: digit 0 re-seen with same value (no event), digit 1 becomes "7"
    dwell(4'b1110, 7'h40, 8, 0, '0, '0, 0, 0);
    dwell(4'b1101, 7'h78, 8, 1, 16'hA270, 4'b1111, 0, 0);

    // illegal then blank on digit 1, then complete the frame with "F","b"
    dwell(4'b1101, 7'h7E, 8, 1, 16'hA270, 4'b1101, 0, 1);
    dwell(4'b1101, 7'h7F, 8, 1, 16'hA200, 4'b1101, 0, 0);
    dwell(4'b1011, 7'h0E, 8, 1, 16'hAF00, 4'b1101, 0, 0);
    dwell(4'b0111, 7'h03, 8, 1, 16'hBF00, 4'b1101, 1, 0);

    // ghosting must not touch seen: frame only after all four digits
    dwell(4'b1100, 7'h30, 20, 0, '0, '0, 0, 0);
    dwell(4'b1111, 7'h7F, 10, 0, '0, '0, 0, 0);
    dwell(4'b1011, 7'h40, 8, 1, 16'hB000, 4'b1101, 0, 0);
    dwell(4'b0111, 7'h30, 8, 1, 16'h3000, 4'b1101, 0, 0);
    dwell(4'b1110, 7'h79, 8, 1, 16'h3001, 4'b1101, 0, 0);
    dwell(4'b1101, 7'h24, 8, 1, 16'h3021, 4'b1111, 1, 0);

    // async reset at count 3 of a dwell, release with inputs held
    dwell(4'b1110, 7'h00, 5, 0, '0, '0, 0, 0);
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset_clear");
    repeat (3) @(posedge clk);
    #2;
    x.at = cyc + 6; x.d = 16'h0008; x.v = 4'b0001; x.f = 0; x.e = 0;
    q.push_back(x);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_events got=%0d pending want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d cycles want finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
